// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one scoreboard write-back port among NR_REQ functional units
module wb_arbiter #(
  parameter int NR_REQ        = 4,
  parameter int TRANS_ID_BITS = 3,
  parameter int EX_BITS       = 129
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic [NR_REQ-1:0]                       valid_i,
  output logic [NR_REQ-1:0]                       ready_o,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]    trans_id_i,
  input  logic [NR_REQ-1:0][63:0]                 wbdata_i,
  input  logic [NR_REQ-1:0][EX_BITS-1:0]          ex_i,
  output logic [TRANS_ID_BITS-1:0]                trans_id_o,
  output logic [63:0]                             wbdata_o,
  output logic [EX_BITS-1:0]                      ex_o,
  output logic                                    wb_valid_o,
  output logic [NR_REQ-1:0]                       grant_o
);
  localparam int PTR_BITS = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  logic [NR_REQ-1:0]                    r_hold_valid;
  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] r_hold_id;
  logic [NR_REQ-1:0][63:0]              r_hold_data;
  logic [NR_REQ-1:0][EX_BITS-1:0]       r_hold_ex;
  logic [PTR_BITS-1:0]                  r_rr_ptr;
  logic [PTR_BITS:0]                    w_sum;
  logic [PTR_BITS-1:0]                  w_idx;
  logic [PTR_BITS-1:0]                  w_gidx;
  logic [PTR_BITS-1:0]                  w_ptr_nxt;
  logic                                 w_any;
  logic [NR_REQ-1:0]                    w_capture;

  // scan holders from the pointer upward, wrapping explicitly at NR_REQ so odd counts work
  always_comb begin
    w_sum  = '0;
    w_idx  = '0;
    w_gidx = '0;
    w_any  = 1'b0;
    for (int k = 0; k < NR_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_BITS+1)'(k);
      w_idx = (w_sum >= (PTR_BITS+1)'(NR_REQ)) ? PTR_BITS'(w_sum - (PTR_BITS+1)'(NR_REQ)) : PTR_BITS'(w_sum);
      if (!w_any && r_hold_valid[w_idx]) begin
        w_any  = 1'b1;
        w_gidx = w_idx;
      end
    end
  end

  // grant, write-back mux and acceptance; flush masks everything so stale results never escape
  always_comb begin
    wb_valid_o = w_any && !flush_i;
    grant_o    = wb_valid_o ? (NR_REQ'(1) << w_gidx) : '0;
    trans_id_o = wb_valid_o ? r_hold_id[w_gidx] : '0;
    wbdata_o   = wb_valid_o ? r_hold_data[w_gidx] : '0;
    ex_o       = wb_valid_o ? r_hold_ex[w_gidx] : '0;
    ready_o    = {NR_REQ{!flush_i}} & (~r_hold_valid | grant_o);
    w_capture  = valid_i & ready_o;
    w_ptr_nxt  = (w_gidx == PTR_BITS'(NR_REQ - 1)) ? '0 : w_gidx + 1'b1;
  end

  // holder occupancy and round-robin pointer; a capture on a granted holder keeps it valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold_valid <= '0;
      r_rr_ptr     <= '0;
    end else if (flush_i) begin
      r_hold_valid <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_hold_valid <= w_capture | (r_hold_valid & ~grant_o);
      r_rr_ptr     <= wb_valid_o ? w_ptr_nxt : r_rr_ptr;
    end
  end

  // holder payload, loaded only on capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold_id   <= '0;
      r_hold_data <= '0;
      r_hold_ex   <= '0;
    end else begin
      for (int i = 0; i < NR_REQ; i++) begin
        r_hold_id[i]   <= w_capture[i] ? trans_id_i[i] : r_hold_id[i];
        r_hold_data[i] <= w_capture[i] ? wbdata_i[i] : r_hold_data[i];
        r_hold_ex[i]   <= w_capture[i] ? ex_i[i] : r_hold_ex[i];
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for the round-robin write-back arbiter
module tb_wb_arbiter;
  localparam int N   = 4;
  localparam int TID = 6;
  localparam int EXW = 129;
  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     flush_i = 1'b0;
  logic [N-1:0]             valid_i = '0;
  logic [N-1:0]             ready_o;
  logic [N-1:0][TID-1:0]    trans_id_i = '0;
  logic [N-1:0][63:0]       wbdata_i = '0;
  logic [N-1:0][EXW-1:0]    ex_i = '0;
  logic [TID-1:0]           trans_id_o;
  logic [63:0]              wbdata_o;
  logic [EXW-1:0]           ex_o;
  logic                     wb_valid_o;
  logic [N-1:0]             grant_o;
  typedef struct {
    logic           v;
    logic [N-1:0]   g;
    logic [TID-1:0] id;
  } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.NR_REQ(N), .TRANS_ID_BITS(TID), .EX_BITS(EXW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .trans_id_i(trans_id_i), .wbdata_i(wbdata_i), .ex_i(ex_i),
    .trans_id_o(trans_id_o), .wbdata_o(wbdata_o), .ex_o(ex_o),
    .wb_valid_o(wb_valid_o), .grant_o(grant_o)
  );

  function automatic logic [63:0] data_of(input logic v, input logic [TID-1:0] id);
    return v ? {16'hA5A5, 42'h0, id} : 64'h0;
  endfunction

  function automatic logic [EXW-1:0] ex_of(input logic v, input logic [TID-1:0] id);
    return v ? {1'b1, 122'h0, id} : '0;
  endfunction

  function automatic exp_t next_exp();
    exp_t e;
    e = '{1'b0, '0, '0};
    if (q.size() != 0) e = q.pop_front();
    return e;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [TID-1:0] a, b, c, d, input logic f);
    valid_i    = v;
    trans_id_i = {d, c, b, a};
    for (int i = 0; i < N; i++) begin
      wbdata_i[i] = data_of(1'b1, trans_id_i[i]);
      ex_i[i]     = ex_of(1'b1, trans_id_i[i]);
    end
    flush_i = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive('0, '0, '0, '0, '0, 1'b0);
    tick();
    rst_ni = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    drive('0, '0, '0, '0, '0, 1'b0);
    n_vec++;
    if ({wb_valid_o, grant_o, ready_o} !== {1'b0, 4'b0000, 4'b1111} || trans_id_o !== '0 || wbdata_o !== 64'h0 || ex_o !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b g=%b rdy=%b id=%0d, want v=0 g=0000 rdy=1111 id=0", wb_valid_o, grant_o, ready_o, trans_id_o);
    end
    rst_ni = 1'b1;
    tick();
    drive(4'b0001, 6'd1, '0, '0, '0, 1'b0);
    tick();
    drive('0, '0, '0, '0, '0, 1'b0);
    n_vec++;
    if (wb_valid_o !== 1'b1 || trans_id_o !== 6'd1) begin
      n_err++;
      $display("FAIL reset_pre_hold: got v=%b id=%0d, want v=1 id=1", wb_valid_o, trans_id_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({wb_valid_o, grant_o, ready_o} !== {1'b0, 4'b0000, 4'b1111} || trans_id_o !== '0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b g=%b rdy=%b id=%0d, want v=0 g=0000 rdy=1111 id=0", wb_valid_o, grant_o, ready_o, trans_id_o);
    end
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if (wb_valid_o !== 1'b0 || grant_o !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_idle c%0d: got v=%b g=%b, want v=0 g=0000", c, wb_valid_o, grant_o);
      end
    end
  endtask

  task automatic test_stream();
    exp_t e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c < 5) drive(4'b0010, '0, TID'(c), '0, '0, 1'b0);
      else drive('0, '0, '0, '0, '0, 1'b0);
      e = next_exp();
      n_vec++;
      if ({wb_valid_o, grant_o, trans_id_o} !== {e.v, e.g, e.id} || wbdata_o !== data_of(e.v, e.id) || ex_o !== ex_of(e.v, e.id)) begin
        n_err++;
        $display("FAIL stream c%0d: got v=%b g=%b id=%0d, want v=%b g=%b id=%0d", c, wb_valid_o, grant_o, trans_id_o, e.v, e.g, e.id);
      end
      if (c < 5) begin
        n_vec++;
        if (ready_o[1] !== 1'b1) begin
          n_err++;
          $display("FAIL stream_ready c%0d: got %b, want 1", c, ready_o[1]);
        end
        q.push_back('{1'b1, 4'b0010, TID'(c)});
      end
      tick();
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain: got %0d pending, want 0", q.size());
    end
  endtask

  task automatic test_contention();
    exp_t e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(4'b1111, 6'd4, 6'd5, 6'd6, 6'd7, 1'b0);
      else drive('0, '0, '0, '0, '0, 1'b0);
      e = next_exp();
      n_vec++;
      if ({wb_valid_o, grant_o, trans_id_o} !== {e.v, e.g, e.id} || wbdata_o !== data_of(e.v, e.id) || ex_o !== ex_of(e.v, e.id)) begin
        n_err++;
        $display("FAIL contention c%0d: got v=%b g=%b id=%0d, want v=%b g=%b id=%0d", c, wb_valid_o, grant_o, trans_id_o, e.v, e.g, e.id);
      end
      if (c == 0) begin
        q.push_back('{1'b1, 4'b0001, 6'd4});
        q.push_back('{1'b1, 4'b0010, 6'd5});
        q.push_back('{1'b1, 4'b0100, 6'd6});
        q.push_back('{1'b1, 4'b1000, 6'd7});
      end
      tick();
    end
  endtask

  task automatic test_rr_wrap();
    exp_t e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(4'b1000, '0, '0, '0, 6'd10, 1'b0);
      else if (c == 1) drive(4'b1001, 6'd11, '0, '0, 6'd12, 1'b0);
      else drive('0, '0, '0, '0, '0, 1'b0);
      e = next_exp();
      n_vec++;
      if ({wb_valid_o, grant_o, trans_id_o} !== {e.v, e.g, e.id} || wbdata_o !== data_of(e.v, e.id)) begin
        n_err++;
        $display("FAIL rr_wrap c%0d: got v=%b g=%b id=%0d, want v=%b g=%b id=%0d", c, wb_valid_o, grant_o, trans_id_o, e.v, e.g, e.id);
      end
      if (c == 0) q.push_back('{1'b1, 4'b1000, 6'd10});
      if (c == 1) begin
        q.push_back('{1'b1, 4'b0001, 6'd11});
        q.push_back('{1'b1, 4'b1000, 6'd12});
      end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    exp_t e;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive(4'b0101, 6'd20, '0, 6'd21, '0, 1'b0);
      else if (c == 1) drive(4'b0101, 6'd22, '0, 6'd23, '0, 1'b0);
      else if (c == 2) drive(4'b0100, '0, '0, 6'd23, '0, 1'b0);
      else drive('0, '0, '0, '0, '0, 1'b0);
      e = next_exp();
      n_vec++;
      if ({wb_valid_o, grant_o, trans_id_o} !== {e.v, e.g, e.id} || wbdata_o !== data_of(e.v, e.id)) begin
        n_err++;
        $display("FAIL back_pressure c%0d: got v=%b g=%b id=%0d, want v=%b g=%b id=%0d", c, wb_valid_o, grant_o, trans_id_o, e.v, e.g, e.id);
      end
      if (c == 1 || c == 2) begin
        n_vec++;
        if (ready_o !== ((c == 1) ? 4'b1011 : 4'b1110)) begin
          n_err++;
          $display("FAIL back_pressure_ready c%0d: got %b, want %b", c, ready_o, (c == 1) ? 4'b1011 : 4'b1110);
        end
      end
      if (c == 0) begin
        q.push_back('{1'b1, 4'b0001, 6'd20});
        q.push_back('{1'b1, 4'b0100, 6'd21});
      end
      if (c == 1) q.push_back('{1'b1, 4'b0001, 6'd22});
      if (c == 2) q.push_back('{1'b1, 4'b0100, 6'd23});
      tick();
    end
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 0) drive(4'b0100, '0, '0, 6'd40, '0, 1'b0);
      else if (c == 1) drive(4'b0111, 6'd41, 6'd42, 6'd43, '0, 1'b0);
      else if (c == 2) drive(4'b0001, 6'd44, '0, '0, '0, 1'b1);
      else if (c == 3) drive(4'b1010, '0, 6'd45, '0, 6'd46, 1'b0);
      else drive('0, '0, '0, '0, '0, 1'b0);
      e = next_exp();
      n_vec++;
      if ({wb_valid_o, grant_o, trans_id_o} !== {e.v, e.g, e.id} || wbdata_o !== data_of(e.v, e.id) || ex_o !== ex_of(e.v, e.id)) begin
        n_err++;
        $display("FAIL flush c%0d: got v=%b g=%b id=%0d, want v=%b g=%b id=%0d", c, wb_valid_o, grant_o, trans_id_o, e.v, e.g, e.id);
      end
      if (c == 2 || c == 3) begin
        n_vec++;
        if (ready_o !== ((c == 2) ? 4'b0000 : 4'b1111)) begin
          n_err++;
          $display("FAIL flush_ready c%0d: got %b, want %b", c, ready_o, (c == 2) ? 4'b0000 : 4'b1111);
        end
      end
      if (c == 0) q.push_back('{1'b1, 4'b0100, 6'd40});
      if (c == 3) begin
        q.push_back('{1'b1, 4'b0010, 6'd45});
        q.push_back('{1'b1, 4'b1000, 6'd46});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_contention();
    test_rr_wrap();
    test_back_pressure();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
